// File: rtl/level_tile_rom_pkg.sv
// Level data for the room-based world: tile geometry, per-room wall maps and door masks.
// Door carving is applied by level_tile_rom when LEVEL_ROM_DOORS_EN is defined.
package level_pkg;

    localparam int TILE_SHIFT = 5;
    localparam int MAP_W      = 20;
    localparam int MAP_H      = 15;
    localparam int NUM_ROOMS  = 8;
    localparam int COORD_W    = 10;
    localparam int ROOM_W     = 3;
    localparam int TX_W       = 5;
    localparam int TY_W       = 4;

    localparam logic [TY_W-1:0] DOOR_N_ROW  = 4'd0;
    localparam logic [TY_W-1:0] DOOR_S_ROW  = 4'd14;
    localparam logic [TY_W-1:0] DOOR_ROW_LO = 4'd7;
    localparam logic [TY_W-1:0] DOOR_ROW_HI = 4'd8;
    localparam logic [TX_W-1:0] DOOR_W_COL  = 5'd0;
    localparam logic [TX_W-1:0] DOOR_E_COL  = 5'd19;
    localparam logic [TX_W-1:0] DOOR_COL_LO = 5'd9;
    localparam logic [TX_W-1:0] DOOR_COL_HI = 5'd10;

    // Bit positions inside a door mask, ordered {N,S,W,E}.
    typedef enum logic [1:0] {
        DOOR_E = 2'd0,
        DOOR_W = 2'd1,
        DOOR_S = 2'd2,
        DOOR_N = 2'd3
    } door_e;

    typedef logic [MAP_W-1:0]          row_t;
    typedef row_t [MAP_H-1:0]          room_map_t;
    typedef room_map_t [NUM_ROOMS-1:0] level_map_t;
    typedef logic [3:0]                door_mask_t;

    // Solid border everywhere; rooms 1-7 get a scattered pillar pattern that
    // keeps a one-tile walkway just inside the border.
    function automatic level_map_t build_room_map();
        level_map_t m;
        for (int r = 0; r < NUM_ROOMS; r++) begin
            for (int ty = 0; ty < MAP_H; ty++) begin
                for (int tx = 0; tx < MAP_W; tx++) begin
                    if (ty == 0 || ty == MAP_H - 1 || tx == 0 || tx == MAP_W - 1)
                        m[r][ty][tx] = 1'b1;
                    else if (r != 0 && ty >= 2 && ty <= MAP_H - 3 && tx >= 2 && tx <= MAP_W - 3)
                        m[r][ty][tx] = (((tx * 3 + ty * r) % (r + 5)) == 0);
                    else
                        m[r][ty][tx] = 1'b0;
                end
            end
        end
        return m;
    endfunction

    localparam level_map_t ROOM_MAP = build_room_map();

    localparam door_mask_t [NUM_ROOMS-1:0] DOOR_MASK = {
        4'b0010,  // room 7
        4'b0101,  // room 6
        4'b1000,  // room 5
        4'b0110,  // room 4
        4'b1001,  // room 3
        4'b0011,  // room 2
        4'b1100,  // room 1
        4'b1111   // room 0
    };

endpackage

// File: rtl/level_tile_rom_if.sv
// Lookup bus between a tile-map client (master) and level_tile_rom (slave).
interface level_tile_rom_if;
    import level_pkg::*;

    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic [ROOM_W-1:0]  room;
    logic               bg_type;
    logic               bg_type_q;

    modport master (output DrawX, output DrawY, output room, input bg_type, input bg_type_q);
    modport slave  (input DrawX, input DrawY, input room, output bg_type, output bg_type_q);
endinterface

// File: rtl/level_tile_rom_tile_index.sv
// Pixel coordinate to tile index conversion plus on-screen range check.
module tile_index
    import level_pkg::*;
#(
    parameter int TILE_SHIFT = level_pkg::TILE_SHIFT,
    parameter int MAP_W      = level_pkg::MAP_W,
    parameter int MAP_H      = level_pkg::MAP_H
) (
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic [TX_W-1:0]    tx,
    output logic [TY_W-1:0]    ty,
    output logic               in_range
);
    localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(MAP_W << TILE_SHIFT);
    localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(MAP_H << TILE_SHIFT);

    assign tx       = DrawX[TILE_SHIFT +: TX_W];
    assign ty       = DrawY[TILE_SHIFT +: TY_W];
    // Wrapped negative coordinates land far above the limits and read as off-screen.
    assign in_range = (DrawX < X_LIMIT) && (DrawY < Y_LIMIT);
endmodule

// File: rtl/level_tile_rom.sv
// Room tile map lookup: combinational wall/floor answer plus one registered copy.
// Define LEVEL_ROM_DOORS_EN to carve door openings from DOOR_MASK; otherwise rooms are closed.
module level_tile_rom #(
    parameter int TILE_SHIFT = level_pkg::TILE_SHIFT,
    parameter int MAP_W      = level_pkg::MAP_W,
    parameter int MAP_H      = level_pkg::MAP_H,
    parameter int NUM_ROOMS  = level_pkg::NUM_ROOMS
) (
    input  logic              Clk,
    input  logic              Reset,
    level_tile_rom_if.slave   bus
);
    import level_pkg::*;

    localparam int RIDX_W = $clog2(NUM_ROOMS);

    logic [TX_W-1:0]   tx;
    logic [TY_W-1:0]   ty;
    logic              in_range;
    logic [RIDX_W-1:0] room_idx;
    room_map_t         room_map;
    row_t              row_bits;
    logic              map_bit;
    logic [3:0]        door_hit;
    logic              bg_type_next;
    logic              bg_type_q_reg;

    tile_index #(
        .TILE_SHIFT (TILE_SHIFT),
        .MAP_W      (MAP_W),
        .MAP_H      (MAP_H)
    ) u_tile_index (
        .DrawX    (bus.DrawX),
        .DrawY    (bus.DrawY),
        .tx       (tx),
        .ty       (ty),
        .in_range (in_range)
    );

    assign room_idx = bus.room[RIDX_W-1:0];
    assign room_map = ROOM_MAP[room_idx];
    assign row_bits = room_map[ty];
    assign map_bit  = row_bits[tx];

`ifdef LEVEL_ROM_DOORS_EN
    logic [3:0] door_cell;
    door_mask_t door_mask;

    assign door_mask         = DOOR_MASK[room_idx];
    assign door_cell[DOOR_N] = (ty == DOOR_N_ROW) && (tx == DOOR_COL_LO || tx == DOOR_COL_HI);
    assign door_cell[DOOR_S] = (ty == DOOR_S_ROW) && (tx == DOOR_COL_LO || tx == DOOR_COL_HI);
    assign door_cell[DOOR_W] = (tx == DOOR_W_COL) && (ty == DOOR_ROW_LO || ty == DOOR_ROW_HI);
    assign door_cell[DOOR_E] = (tx == DOOR_E_COL) && (ty == DOOR_ROW_LO || ty == DOOR_ROW_HI);

    for (genvar gi = 0; gi < 4; gi++) begin : g_door
        assign door_hit[gi] = door_cell[gi] & door_mask[gi];
    end
`else
    assign door_hit = '0;
`endif

    // Off-screen must be floor so the player can walk out and trigger a room change.
    assign bg_type_next = in_range & map_bit & ~(|door_hit);
    assign bus.bg_type  = bg_type_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            bg_type_q_reg <= 1'b0;
        else
            bg_type_q_reg <= bg_type_next;
    end

    assign bus.bg_type_q = bg_type_q_reg;
endmodule

// File: tb/tb_level_tile_rom.sv
// Self-checking bench for level_tile_rom: directed vectors, full tile-centre sweep,
// asynchronous reset behaviour and randomized pipeline checks against a behavioural model.
module tb_level_tile_rom;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    level_tile_rom_if bus ();

    level_tile_rom dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural answer computed from screen geometry and the level tables.
    function automatic logic model_bg(int x, int y, int r);
        int tx;
        int ty;
        if (x >= 640 || y >= 480) return 1'b0;
        tx = x / 32;
        ty = y / 32;
`ifdef LEVEL_ROM_DOORS_EN
        if (ty == 0  && (tx == 9 || tx == 10) && level_pkg::DOOR_MASK[r][3]) return 1'b0;
        if (ty == 14 && (tx == 9 || tx == 10) && level_pkg::DOOR_MASK[r][2]) return 1'b0;
        if (tx == 0  && (ty == 7 || ty == 8)  && level_pkg::DOOR_MASK[r][1]) return 1'b0;
        if (tx == 19 && (ty == 7 || ty == 8)  && level_pkg::DOOR_MASK[r][0]) return 1'b0;
`endif
        return level_pkg::ROOM_MAP[r][ty][tx];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input int r);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.room  = 3'(r);
    endtask

    task automatic probe(input string tag, input int x, input int y, input int r, input logic exp);
        drive(x, y, r);
        #1;
        check($sformatf("%s r%0d (%0d,%0d)", tag, r, x, y), bus.bg_type, exp);
        $display("lookup %s room=%0d x=%0d y=%0d bg_type=%0b", tag, r, x, y, bus.bg_type);
    endtask

    logic door_exp;
    logic exp_q;
    int   rx, ry, rr;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef LEVEL_ROM_DOORS_EN
        door_exp = 1'b0;
`else
        door_exp = 1'b1;
`endif

        // Reset held: register at 0 while the lookup itself is live.
        reset = 1'b1;
        drive(5, 100, 0);
        #1;
        check("reset_q_async", bus.bg_type_q, 1'b0);
        check("reset_bg_live", bus.bg_type, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_q_hold", bus.bg_type_q, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_q_before_edge", bus.bg_type_q, 1'b0);
        @(posedge clk);
        #1;
        check("release_q_first_edge", bus.bg_type_q, 1'b1);
        $display("reset release bg_type_q=%0b", bus.bg_type_q);

        // Mid-cycle reset clears the register without waiting for an edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midcycle_reset_q", bus.bg_type_q, 1'b0);
        @(posedge clk);
        #1;
        check("midcycle_reset_hold", bus.bg_type_q, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed lookups.
        probe("centre",      320, 240, 0, 1'b0);
        probe("west_wall",     5, 100, 0, 1'b1);
        probe("north_door",  300,  10, 0, door_exp);
        probe("north_solid", 250,  10, 0, 1'b1);
        probe("east_door",   630, 230, 0, door_exp);
        probe("x31",          31, 100, 0, 1'b1);
        probe("x32",          32, 100, 0, 1'b0);
        probe("y447",        100, 447, 0, 1'b0);
        probe("y448",        100, 448, 0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            probe("oor_x642",  642, 240, r, 1'b0);
            probe("oor_x1021", 1021, 240, r, 1'b0);
            probe("oor_y500",  320, 500, r, 1'b0);
            probe("oor_x640",  640, 100, r, 1'b0);
            probe("oor_y480",    5, 480, r, 1'b0);
        end

        // Every tile centre of every room against the model.
        for (int r = 0; r < 8; r++) begin
            for (int ty = 0; ty < 15; ty++) begin
                for (int tx = 0; tx < 20; tx++) begin
                    drive(16 + 32 * tx, 16 + 32 * ty, r);
                    #1;
                    check($sformatf("sweep r%0d t(%0d,%0d)", r, tx, ty), bus.bg_type,
                          model_bg(16 + 32 * tx, 16 + 32 * ty, r));
                end
            end
            $display("sweep room=%0d done", r);
        end

        // Random stream: new inputs land mid-cycle, register must lag by one edge.
        @(negedge clk);
        drive(5, 100, 0);
        exp_q = model_bg(5, 100, 0);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("pipe_q step%0d", i), bus.bg_type_q, exp_q);
            rr = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                rx = int'($urandom_range(0, 1023));
                ry = int'($urandom_range(0, 1023));
            end else begin
                rx = int'($urandom_range(0, 639));
                ry = int'($urandom_range(0, 479));
            end
            #1;
            drive(rx, ry, rr);
            #1;
            check($sformatf("pipe_bg step%0d", i), bus.bg_type, model_bg(rx, ry, rr));
            check($sformatf("pipe_q_lag step%0d", i), bus.bg_type_q, exp_q);
            $display("step %0d room=%0d x=%0d y=%0d bg_type=%0b bg_type_q=%0b",
                     i, rr, rx, ry, bus.bg_type, bus.bg_type_q);
            exp_q = model_bg(rx, ry, rr);
        end
        @(posedge clk);
        #1;
        check("pipe_q_final", bus.bg_type_q, exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
